// File: rtl/regarb_pkg.sv
// Shared types and sizes for the two-port register-bank arbiter.
package regarb_pkg;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Command captured from the winning requester when it is granted.
    typedef struct packed {
        logic              who;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    // Requester index to its bit in the gnt/rvalid vectors.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/reg_bank_8x16.sv
// 8 x 16-bit register file: one write port, combinational read port, async clear.
module reg_bank_8x16
    import regarb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage update: clear everything on reset, otherwise single-port write.
    // NOTE: these registers must read as zero after reset, so they are plain
    // flops with a clear; a RAM macro could not be reset this way.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter giving two requesters read/write access to an 8x16 bank.
module reg_bank_arbiter
    import regarb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              last_q;
    logic              winner;
    logic              take;
    logic              bank_we;
    logic [DATA_W-1:0] bank_rdata;

    // State register, command latch and last-granted pointer.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            last_q  <= 1'b1;  // requester 0 wins the first tie
        end else begin
            state_q <= state_d;
            if (take) begin
                cmd_q  <= cmd_d;
                last_q <= winner;
            end
        end
    end

    // Arbitration, next state and outputs decoded from the registered state.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        winner  = last_q;
        take    = 1'b0;
        gnt     = 2'b00;
        rvalid  = 2'b00;
        rdata   = '0;
        bank_we = 1'b0;

        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_q;
            default: winner = last_q;
        endcase

        cmd_d.who   = winner;
        cmd_d.we    = we[winner];
        cmd_d.addr  = winner ? addr1 : addr0;
        cmd_d.wdata = winner ? wdata1 : wdata0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    take    = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                gnt     = onehot2(cmd_q.who);
                bank_we = cmd_q.we;
                state_d = cmd_q.we ? IDLE : RESP;
            end
            RESP: begin
                rvalid  = onehot2(cmd_q.who);
                rdata   = bank_rdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    reg_bank_8x16 u_bank (
        .Clk   (Clk),
        .Reset (Reset),
        .we    (bank_we),
        .waddr (cmd_q.addr),
        .wdata (cmd_q.wdata),
        .raddr (cmd_q.addr),
        .rdata (bank_rdata)
    );

endmodule
